// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-specifier width, data width, register count
// and the index/data types used by the register file and its scoreboard.
package cpu_pkg;

    localparam int REG_AW = 3;
    localparam int DW     = 8;
    localparam int NREGS  = 8;

    typedef logic [2:0] reg_idx_t;
    typedef logic [7:0] data_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register in-flight write scoreboard for decode.
// Tracks issued-but-not-written destination registers with 2-bit counters,
// raises a sticky flag on counter overflow/underflow and produces the decode stall.
// Optional macro WB_REGFILE_BYPASS_EN: a source whose last pending write lands
// this cycle is treated as ready (its value is forwarded by the register file).
module wb_scoreboard #(
    parameter int NREGS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_regwrite,
    input  logic [2:0] wb_writereg,
    input  logic [2:0] id_rs1,
    input  logic [2:0] id_rs2,
    input  logic       id_rs1_en,
    input  logic       id_rs2_en,
    input  logic       id_issue,
    input  logic       id_rd_we,
    input  logic [2:0] id_rd,
    output logic       stall,
    output logic       sb_overflow
);
    import cpu_pkg::*;

    logic [1:0]       pend [NREGS];
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic             acc;
    logic [1:0]       eff1;
    logic [1:0]       eff2;

    // Writeback retiring a pending write, one-hot per register
    always_comb begin
        dec = '0;
        for (int r = 0; r < NREGS; r++)
            dec[r] = wb_regwrite && (wb_writereg == reg_idx_t'(r));
    end

    // Effective pending count seen by each source, plus the resulting stall
    always_comb begin
        eff1 = pend[id_rs1];
        eff2 = pend[id_rs2];
`ifdef WB_REGFILE_BYPASS_EN
        if (dec[id_rs1] && (eff1 != 2'd0)) eff1 = eff1 - 2'd1;
        if (dec[id_rs2] && (eff2 != 2'd0)) eff2 = eff2 - 2'd1;
`endif
        stall = id_issue && ((id_rs1_en && (eff1 != 2'd0)) ||
                             (id_rs2_en && (eff2 != 2'd0)));
    end

    // Accepted issue adds a pending write to its destination
    always_comb begin
        acc = id_issue && id_rd_we && !stall;
        inc = '0;
        for (int r = 0; r < NREGS; r++)
            inc[r] = acc && (id_rd == reg_idx_t'(r));
    end

    // Saturating pending counters and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++)
                pend[r] <= 2'd0;
            sb_overflow <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (inc[r] && !dec[r]) begin
                    if (pend[r] == 2'd3) sb_overflow <= 1'b1;
                    else                 pend[r] <= pend[r] + 2'd1;
                end else if (dec[r] && !inc[r]) begin
                    if (pend[r] == 2'd0) sb_overflow <= 1'b1;
                    else                 pend[r] <= pend[r] - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// 8x8 register file fed by the writeback stage, serving two combinational
// read ports to decode, with an in-flight write scoreboard for RAW stalls.
// Optional macro WB_REGFILE_BYPASS_EN: forwards the writeback data to a read
// port addressing the register being written in the same cycle.
module wb_regfile #(
    parameter int NREGS = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_regwrite,
    input  logic          wb_loadimm,
    input  logic [DW-1:0] wb_alures,
    input  logic [DW-1:0] wb_immdata,
    input  logic [2:0]    wb_writereg,
    input  logic [2:0]    id_rs1,
    input  logic [2:0]    id_rs2,
    input  logic          id_rs1_en,
    input  logic          id_rs2_en,
    input  logic          id_issue,
    input  logic          id_rd_we,
    input  logic [2:0]    id_rd,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          stall,
    output logic          sb_overflow
);
    import cpu_pkg::*;

    logic [DW-1:0] regs [NREGS];
    logic [DW-1:0] wdata;

    // Writeback data select: immediate load or ALU result
    always_comb begin
        wdata = wb_loadimm ? wb_immdata : wb_alures;
    end

    // Register array, cleared on reset, written at the clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else if (wb_regwrite) begin
            regs[wb_writereg] <= wdata;
        end
    end

    // Combinational read ports with optional same-cycle writeback forwarding
    always_comb begin
        rd1 = regs[id_rs1];
        rd2 = regs[id_rs2];
`ifdef WB_REGFILE_BYPASS_EN
        if (wb_regwrite && (wb_writereg == id_rs1)) rd1 = wdata;
        if (wb_regwrite && (wb_writereg == id_rs2)) rd2 = wdata;
`endif
    end

    wb_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .wb_regwrite (wb_regwrite),
        .wb_writereg (wb_writereg),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_en   (id_rs1_en),
        .id_rs2_en   (id_rs2_en),
        .id_issue    (id_issue),
        .id_rd_we    (id_rd_we),
        .id_rd       (id_rd),
        .stall       (stall),
        .sb_overflow (sb_overflow)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wb_regwrite = 1'b0, wb_loadimm = 1'b0;
    logic [7:0] wb_alures = '0, wb_immdata = '0;
    logic [2:0] wb_writereg = '0;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_rs1_en = 1'b0, id_rs2_en = 1'b0, id_issue = 1'b0, id_rd_we = 1'b0;
    logic [7:0] rd1, rd2;
    logic       stall, sb_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [7:0] rd1;
        bit         c1;
        logic [7:0] rd2;
        bit         c2;
        logic       stall;
        logic       ovf;
    } exp_t;

    exp_t q[$];

    wb_regfile #(.NREGS(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .wb_regwrite(wb_regwrite), .wb_loadimm(wb_loadimm),
        .wb_alures(wb_alures), .wb_immdata(wb_immdata), .wb_writereg(wb_writereg),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_issue(id_issue), .id_rd_we(id_rd_we), .id_rd(id_rd),
        .rd1(rd1), .rd2(rd2), .stall(stall), .sb_overflow(sb_overflow)
    );

    always #5 clk = ~clk;

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.c1) begin
                n_cmp++;
                if (rd1 !== e.rd1) begin
                    n_bad++;
                    $display("FAIL %s rd1: got %02h expected %02h", e.name, rd1, e.rd1);
                end
            end
            if (e.c2) begin
                n_cmp++;
                if (rd2 !== e.rd2) begin
                    n_bad++;
                    $display("FAIL %s rd2: got %02h expected %02h", e.name, rd2, e.rd2);
                end
            end
            n_cmp++;
            if (stall !== e.stall) begin
                n_bad++;
                $display("FAIL %s stall: got %b expected %b", e.name, stall, e.stall);
            end
            n_cmp++;
            if (sb_overflow !== e.ovf) begin
                n_bad++;
                $display("FAIL %s sb_overflow: got %b expected %b", e.name, sb_overflow, e.ovf);
            end
        end
    end

    task automatic expect_out(input string name, input logic [7:0] e1, input bit c1,
                              input logic [7:0] e2, input bit c2,
                              input logic est, input logic eovf);
        exp_t e;
        e.name = name; e.rd1 = e1; e.c1 = c1; e.rd2 = e2; e.c2 = c2;
        e.stall = est; e.ovf = eovf;
        q.push_back(e);
    endtask

    // One cycle of stimulus, applied 1ns after the rising edge
    task automatic cyc(input logic we, input logic li, input logic [7:0] alu,
                       input logic [7:0] imm, input logic [2:0] wreg,
                       input logic [2:0] rs1, input logic e1,
                       input logic [2:0] rs2, input logic e2,
                       input logic iss, input logic rdwe, input logic [2:0] rd);
        @(posedge clk);
        #1;
        wb_regwrite = we; wb_loadimm = li; wb_alures = alu; wb_immdata = imm;
        wb_writereg = wreg; id_rs1 = rs1; id_rs1_en = e1; id_rs2 = rs2; id_rs2_en = e2;
        id_issue = iss; id_rd_we = rdwe; id_rd = rd;
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #4 rst = 1'b1;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state while rst is held low
        #1;
        id_rs1 = 3'd3; id_rs1_en = 1'b1; id_issue = 1'b1;
        expect_out("reset_hold", 8'h00, 1, 8'h00, 1, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        idle();

        // Reset mid-operation: unissued write to r3 (flags underflow)
        cyc(1, 0, 8'h5A, 8'h00, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd3, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("pre_reset_r3", 8'h5A, 1, 8'h00, 0, 1'b0, 1'b1);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd3, 1, 3'd3, 1, 1, 0, 3'd0);
        #1 rst = 1'b0;
        expect_out("mid_reset", 8'h00, 1, 8'h00, 1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        idle();

        // Immediate vs ALU write to r2
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd2);
        expect_out("issue_r2", 8'h00, 0, 8'h00, 0, 1'b0, 1'b0);
        cyc(1, 1, 8'hFF, 8'h3C, 3'd2, 3'd2, 0, 3'd0, 0, 0, 0, 3'd0);
        expect_out("wb_imm_same", BYP ? 8'h3C : 8'h00, 1, 8'h00, 0, 1'b0, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd2, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("read_imm", 8'h3C, 1, 8'h00, 0, 1'b0, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd2);
        cyc(1, 0, 8'h81, 8'h00, 3'd2, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd2, 1, 3'd2, 1, 1, 0, 3'd0);
        expect_out("read_alu", 8'h81, 1, 8'h81, 1, 1'b0, 1'b0);

        // RAW hazard on r5
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd5);
        expect_out("issue_r5", 8'h00, 0, 8'h00, 0, 1'b0, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd5, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("raw_stall1", 8'h00, 0, 8'h00, 0, 1'b1, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd5, 1, 3'd0, 0, 0, 0, 3'd0);
        expect_out("raw_no_issue", 8'h00, 0, 8'h00, 0, 1'b0, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd5, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("raw_stall2", 8'h00, 0, 8'h00, 0, 1'b1, 1'b0);
        cyc(1, 0, 8'h77, 8'h00, 3'd5, 3'd5, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("raw_wb_cycle", BYP ? 8'h77 : 8'h00, 1, 8'h00, 0, BYP ? 1'b0 : 1'b1, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd5, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("raw_after", 8'h77, 1, 8'h00, 0, 1'b0, 1'b0);

        // Double in-flight on r1, read through rs2
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd1);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd1);
        expect_out("issue_r1_twice", 8'h00, 0, 8'h00, 0, 1'b0, 1'b0);
        cyc(1, 0, 8'h11, 8'h00, 3'd1, 3'd0, 0, 3'd1, 1, 1, 0, 3'd0);
        expect_out("dbl_wb1", 8'h00, 0, BYP ? 8'h11 : 8'h00, 1, 1'b1, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd1, 1, 1, 0, 3'd0);
        expect_out("dbl_still", 8'h00, 0, 8'h11, 1, 1'b1, 1'b0);
        cyc(1, 1, 8'h00, 8'h22, 3'd1, 3'd0, 0, 3'd1, 1, 1, 0, 3'd0);
        expect_out("dbl_wb2", 8'h00, 0, BYP ? 8'h22 : 8'h11, 1, BYP ? 1'b0 : 1'b1, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd1, 1, 1, 0, 3'd0);
        expect_out("dbl_after", 8'h00, 0, 8'h22, 1, 1'b0, 1'b0);

        // Simultaneous issue and writeback on r4
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd4);
        cyc(1, 0, 8'h44, 8'h00, 3'd4, 3'd0, 0, 3'd0, 0, 1, 1, 3'd4);
        expect_out("simul", 8'h00, 0, 8'h00, 0, 1'b0, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd4, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("simul_haz", 8'h44, 1, 8'h00, 0, 1'b1, 1'b0);
        cyc(1, 0, 8'h45, 8'h00, 3'd4, 3'd4, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("simul_wb", BYP ? 8'h45 : 8'h44, 1, 8'h00, 0, BYP ? 1'b0 : 1'b1, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd4, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("simul_after", 8'h45, 1, 8'h00, 0, 1'b0, 1'b0);

        // Error flag: unissued write to r6
        cyc(1, 0, 8'h66, 8'h00, 3'd6, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0);
        expect_out("err_wb", 8'h00, 0, 8'h00, 0, 1'b0, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd6, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("err_set", 8'h66, 1, 8'h00, 0, 1'b0, 1'b1);
        idle();
        idle();
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd6, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("err_sticky", 8'h66, 1, 8'h00, 0, 1'b0, 1'b1);
        do_reset();
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd6, 1, 3'd0, 0, 1, 0, 3'd0);
        expect_out("err_cleared", 8'h00, 1, 8'h00, 0, 1'b0, 1'b0);

        // Overflow: fourth issue to r7 with pend already 3
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd7);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd7);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd7);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd7);
        expect_out("ovf_before", 8'h00, 0, 8'h00, 0, 1'b0, 1'b0);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 3'd7, 1, 1, 0, 3'd0);
        expect_out("ovf_set", 8'h00, 0, 8'h00, 1, 1'b1, 1'b1);
        idle();

        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

8-entry × 8-bit register file that consumes the write-back stage of the 5-stage pipeline and serves operands to decode. On the write side it takes the EX/WB register outputs and selects immediate data or the ALU result. On the read side it gives decode two combinational read ports, optional WB→ID bypass, and a per-register scoreboard of in-flight writes. The scoreboard raises the decode stall when a source is not yet written.

## Interface
Parameters:
- `NREGS`, default 8: register count. Fixed at 8 because of the 3-bit specifiers.
- `DW`, default 8: data width.

Ports:
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `wb_regwrite` in 1: WB write enable.
- `wb_loadimm` in 1: 1 selects `wb_immdata`; 0 selects `wb_alures`.
- `wb_alures` in 8: ALU result from WB.
- `wb_immdata` in 8: immediate data from WB.
- `wb_writereg` in 3: WB destination register.
- `id_rs1`, `id_rs2` in 3: decode source specifiers.
- `id_rs1_en`, `id_rs2_en` in 1: the source is actually used by the instruction.
- `id_issue` in 1: decode attempts to issue this cycle.
- `id_rd_we` in 1: the issuing instruction writes a register.
- `id_rd` in 3: destination of the issuing instruction.
- `rd1`, `rd2` out 8: operand data, combinational.
- `stall` out 1: decode must hold, combinational.
- `sb_overflow` out 1: sticky scoreboard error flag.

## Operation
- Write data: `wdata = wb_loadimm ? wb_immdata : wb_alures`.
- Write: when `wb_regwrite` is 1, `regs[wb_writereg] <= wdata` at posedge. All 8 registers are writable; there is no hardwired zero.
- Read: `rdN = regs[id_rsN]`, modified by the bypass described in Configuration.
- Scoreboard: one 2-bit counter `pend[r]` per register, counting issued-but-not-written writes. The pipeline allows at most 2 in flight per register.
- Accepted issue: `acc = id_issue & id_rd_we & ~stall`.
- `inc[r] = acc & (id_rd == r)`.
- `dec[r] = wb_regwrite & (wb_writereg == r)`.
- Next-state per register:
  - inc only: +1.
  - dec only: −1.
  - inc and dec together: unchanged.
  - neither: hold.
- Counter boundaries:
  - inc while `pend == 3`: counter stays 3 and `sb_overflow` is set.
  - dec while `pend == 0`: counter stays 0 and `sb_overflow` is set. This covers a write that was never issued.
- `sb_overflow` clears only on reset.
- Hazard per source: `haz_N = id_rsN_en & (pend_eff[id_rsN] != 0)`. `pend_eff` is defined in Configuration.
- `stall = id_issue & (haz_1 | haz_2)`.
- When `id_issue` is 0, `stall` is 0.

## Timing
- Reset (async, `rst` low): all `regs` = 0, all `pend` = 0, `sb_overflow` = 0.
  - Consequences: `rd1`/`rd2` read 0 and `stall` = 0 while in reset.
- Reads and `stall` have zero latency, combinational from inputs and state.
- Writes and scoreboard updates take effect at the next posedge. Data written in cycle N is visible from the array in cycle N+1.
- Reset asserted mid-operation discards all pending counts. The pipeline registers are reset together with this block, so there are no orphaned writebacks.
- Simultaneous WB write and issue to the same register: net count unchanged. The newly issued write remains tracked.

## Configuration
- Macro `WB_REGFILE_BYPASS_EN`.
- Defined:
  - Read bypass: `rdN = wdata` when `wb_regwrite & (wb_writereg == id_rsN)`.
  - `pend_eff[r] = pend[r] − dec[r]`. A source whose final pending write completes this cycle does not stall.
- Undefined:
  - No bypass; `rdN` always reads the array.
  - `pend_eff = pend`. A source stalls until the cycle after its write lands.
  - This costs 1 extra stall cycle per RAW hazard.

## Structure
- Shared package `cpu_pkg` holds:
  - `REG_AW = 3`, `DW = 8`, `NREGS = 8`.
  - `typedef logic [2:0] reg_idx_t`.
  - `typedef logic [7:0] data_t`.
- One natural sub-module, `wb_scoreboard`. It contains:
  - the pend counters and inc/dec logic;
  - the overflow flag;
  - `stall` generation.
- The array, write mux and bypass stay in the top.

## Test plan
- **Reset:** write r3=0x5A, assert `rst` low mid-cycle → `rd1` (rs1=3) = 0x00, all pend = 0, `stall` = 0 immediately.
- **Immediate vs ALU write:**
  - WB write r2 with `loadimm` = 1, imm = 0x3C, alu = 0xFF → next cycle `rd1` (rs1=2) = 0x3C.
  - Then `loadimm` = 0, alu = 0x81 → reads 0x81.
- **RAW hazard:** issue rd=5 (`pend[5]` = 1), then issue with rs1=5, `rs1_en` = 1 → `stall` = 1 each cycle until WB writes r5 = 0x77.
  - With `WB_REGFILE_BYPASS_EN`: `stall` drops in the WB cycle and `rd1` = 0x77 that cycle.
  - Without the macro: `stall` drops the following cycle.
- **Double in-flight:** issue rd=1 twice, so `pend[1]` = 2. First WB write to r1 → reading r1 still stalls. Second WB write → stall clears as in the bypass rule.
- **Simultaneous:** issue rd=4 in the same cycle WB writes r4 with `pend[4]` = 1 → `pend[4]` stays 1, and r4 is read as a hazard next cycle.
- **Error flag:** WB write to r6 with `pend[6]` = 0 → `sb_overflow` = 1, `pend[6]` stays 0, and the flag holds until reset.
